// File: rtl/mem_responder.sv
// Fixed-latency memory responder: tagged LOAD/STORE acceptance, in-order load returns.
// Optional MEM_STALL_EN: refuse every command sampled when a free-running 3-bit counter reads 7.
module mem_responder #(
  parameter int MEM_DEPTH       = 64,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  proc2mem_command,
  input  logic [31:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  output logic [3:0]  mem2proc_transaction_tag,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_data_tag
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  logic [63:0]   mem    [MEM_DEPTH];
  logic [3:0]    q_tag  [MAX_OUTSTANDING];
  logic [63:0]   q_data [MAX_OUTSTANDING];
  logic [3:0]    q_cnt  [MAX_OUTSTANDING];
  logic [PW-1:0] head, tail;
  logic [3:0]    occ;
  logic [3:0]    tag_cnt;

  logic [AW-1:0] idx;
  logic          stall, retire, load_ok, store_ok, accept;
  logic [3:0]    occ_after;
  logic          unused_addr;

  assign idx         = proc2mem_addr[3 +: AW];
  assign unused_addr = ^{proc2mem_addr[31:3+AW], proc2mem_addr[2:0]};

`ifdef MEM_STALL_EN
  logic [2:0] stall_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt <= 3'd0;
    else       stall_cnt <= stall_cnt + 3'd1;
  end
  assign stall = (stall_cnt == 3'd7);
`else
  assign stall = 1'b0;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // The head retires on the edge its countdown is already 0, freeing its slot for a same-edge accept.
  assign retire    = (occ != 4'd0) && (q_cnt[head] == 4'd0);
  assign occ_after = occ - {3'b000, retire};
  assign load_ok   = (proc2mem_command == CMD_LOAD) && !stall && (occ_after < 4'(MAX_OUTSTANDING));
  assign store_ok  = (proc2mem_command == CMD_STORE) && !stall;
  assign accept    = load_ok || store_ok;

  // NOTE: the array is a register file rather than a RAM macro because reset must clear every block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (store_ok) begin
      mem[idx] <= proc2mem_data;
    end
  end

  // NOTE: non-blocking assignments let the head slot be read for the return and rewritten by a new load on one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= 4'd0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        q_tag[i]  <= 4'd0;
        q_data[i] <= 64'd0;
        q_cnt[i]  <= 4'd0;
      end
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        if (q_cnt[i] != 4'd0) q_cnt[i] <= q_cnt[i] - 4'd1;
      if (load_ok) begin
        q_tag[tail]  <= tag_cnt;
        q_data[tail] <= mem[idx];
        q_cnt[tail]  <= 4'(LATENCY - 1);
        tail         <= ptr_inc(tail);
      end
      if (retire) head <= ptr_inc(head);
      occ <= occ_after + {3'b000, load_ok};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_cnt                  <= 4'd1;
      mem2proc_transaction_tag <= 4'd0;
      mem2proc_data_tag        <= 4'd0;
      mem2proc_data            <= 64'd0;
    end else begin
      if (accept) tag_cnt <= (tag_cnt == 4'd15) ? 4'd1 : tag_cnt + 4'd1;
      mem2proc_transaction_tag <= accept ? tag_cnt : 4'd0;
      mem2proc_data_tag        <= retire ? q_tag[head] : 4'd0;
      mem2proc_data            <= retire ? q_data[head] : 64'd0;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at default parameters; the stall scenario runs when MEM_STALL_EN is defined.
module tb_mem_responder;

  localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2, RSVD = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cmd = NONE;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [3:0]  ttag, dtag;
  logic [63:0] rdata;

  int n_checks = 0;
  int n_pass   = 0;

  mem_responder dut (
    .clk                      (clk),
    .reset                    (reset),
    .proc2mem_command         (cmd),
    .proc2mem_addr            (addr),
    .proc2mem_data            (wdata),
    .mem2proc_transaction_tag (ttag),
    .mem2proc_data            (rdata),
    .mem2proc_data_tag        (dtag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_outs(input string tag, input logic [3:0] et, input logic [3:0] ed, input logic [63:0] ev);
    check({tag, ".ttag"}, {60'd0, ttag}, {60'd0, et});
    check({tag, ".dtag"}, {60'd0, dtag}, {60'd0, ed});
    check({tag, ".data"}, rdata, ev);
  endtask

  // Hold reset over two edges, check the cleared outputs, release on a falling edge.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    cmd   = NONE;
    repeat (2) @(posedge clk);
    #1 check_outs(tag, 4'd0, 4'd0, 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present one command, let it be sampled, then check the registered outputs.
  task automatic cyc(input string tag, input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                     input logic [3:0] et, input logic [3:0] ed, input logic [63:0] ev);
    cmd   = c;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1 check_outs(tag, et, ed, ev);
    cmd = NONE;
  endtask

  initial begin
`ifdef MEM_STALL_EN
    // Counter reads (edge-1) mod 8, so loads at edges 8 and 16 are refused.
    apply_reset("st_rst");
    for (int e = 1; e <= 21; e++) begin
      logic [3:0] et, ed;
      et = 4'd0;
      ed = 4'd0;
      case (e)
        4:  et = 4'd1;
        8:  ed = 4'd1;
        12: et = 4'd2;
        16: ed = 4'd2;
        20: et = 4'd3;
        default: ;
      endcase
      cyc($sformatf("st_e%0d", e), (e % 4 == 0) ? LOAD : NONE, 32'h8, 64'd0, et, ed, 64'd0);
    end
`else
    // Store then load of the same block; return 4 edges after the load accept.
    apply_reset("t1_rst");
    cyc("t1_e1", STORE, 32'h08, 64'hDEAD_BEEF_0000_0001, 4'd1, 4'd0, 64'd0);
    cyc("t1_e2", LOAD,  32'h08, 64'd0, 4'd2, 4'd0, 64'd0);
    cyc("t1_e3", NONE,  32'h0,  64'd0, 4'd0, 4'd0, 64'd0);
    cyc("t1_e4", NONE,  32'h0,  64'd0, 4'd0, 4'd0, 64'd0);
    cyc("t1_e5", NONE,  32'h0,  64'd0, 4'd0, 4'd0, 64'd0);
    cyc("t1_e6", NONE,  32'h0,  64'd0, 4'd0, 4'd2, 64'hDEAD_BEEF_0000_0001);
    cyc("t1_e7", NONE,  32'h0,  64'd0, 4'd0, 4'd0, 64'd0);

    // Occupancy: third load refused, store accepted while full, accept on the retire edge.
    apply_reset("t2_rst");
    cyc("t2_e1", LOAD,  32'h00, 64'd0, 4'd1, 4'd0, 64'd0);
    cyc("t2_e2", LOAD,  32'h08, 64'd0, 4'd2, 4'd0, 64'd0);
    cyc("t2_e3", LOAD,  32'h10, 64'd0, 4'd0, 4'd0, 64'd0);
    cyc("t2_e4", STORE, 32'h10, 64'h0123_4567_89AB_CDEF, 4'd3, 4'd0, 64'd0);
    cyc("t2_e5", LOAD,  32'h10, 64'd0, 4'd4, 4'd1, 64'd0);
    cyc("t2_e6", NONE,  32'h0,  64'd0, 4'd0, 4'd2, 64'd0);
    cyc("t2_e7", NONE,  32'h0,  64'd0, 4'd0, 4'd0, 64'd0);
    cyc("t2_e8", NONE,  32'h0,  64'd0, 4'd0, 4'd0, 64'd0);
    cyc("t2_e9", NONE,  32'h0,  64'd0, 4'd0, 4'd4, 64'h0123_4567_89AB_CDEF);

    // Tag wrap 15 -> 1; reserved command neither accepted nor advancing the counter.
    apply_reset("t3_rst");
    for (int i = 0; i < 16; i++)
      cyc($sformatf("t3_st%0d", i), STORE, 32'(i * 8), 64'(i), 4'((i % 15) + 1), 4'd0, 64'd0);
    cyc("t3_rsvd", RSVD,  32'h0, 64'd0, 4'd0, 4'd0, 64'd0);
    cyc("t3_next", STORE, 32'h0, 64'd0, 4'd2, 4'd0, 64'd0);

    // Read-at-accept ordering and address aliasing (0x208 -> block 1).
    apply_reset("t4_rst");
    cyc("t4_e1", STORE, 32'h008, 64'h1111, 4'd1, 4'd0, 64'd0);
    cyc("t4_e2", LOAD,  32'h208, 64'd0,    4'd2, 4'd0, 64'd0);
    cyc("t4_e3", STORE, 32'h008, 64'h2222, 4'd3, 4'd0, 64'd0);
    cyc("t4_e4", LOAD,  32'h008, 64'd0,    4'd4, 4'd0, 64'd0);
    cyc("t4_e5", NONE,  32'h0,   64'd0,    4'd0, 4'd0, 64'd0);
    cyc("t4_e6", NONE,  32'h0,   64'd0,    4'd0, 4'd2, 64'h1111);
    cyc("t4_e7", NONE,  32'h0,   64'd0,    4'd0, 4'd0, 64'd0);
    cyc("t4_e8", NONE,  32'h0,   64'd0,    4'd0, 4'd4, 64'h2222);

    // Asynchronous reset with two loads in flight.
    apply_reset("t5_rst");
    cyc("t5_e1", STORE, 32'h18, 64'h5555, 4'd1, 4'd0, 64'd0);
    cyc("t5_e2", LOAD,  32'h18, 64'd0,    4'd2, 4'd0, 64'd0);
    cyc("t5_e3", LOAD,  32'h18, 64'd0,    4'd3, 4'd0, 64'd0);
    #2 reset = 1'b1;
    #1 check_outs("t5_async", 4'd0, 4'd0, 64'd0);
    apply_reset("t5_hold");
    for (int i = 0; i < 6; i++)
      cyc($sformatf("t5_idle%0d", i), NONE, 32'h0, 64'd0, 4'd0, 4'd0, 64'd0);
    cyc("t5_first", LOAD, 32'h18, 64'd0, 4'd1, 4'd0, 64'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_DEPTH, default 64: number of 64-bit blocks stored; power of two.
REQ-002 Parameter LATENCY, default 4: cycles from load acceptance to data return; legal range 1..15.
REQ-003 Parameter MAX_OUTSTANDING, default 2: maximum loads in flight; legal range 1..LATENCY.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, asynchronous and active-high.
REQ-006 proc2mem_command  input  2  MEM_COMMAND encoding: 0 = NONE, 1 = LOAD, 2 = STORE, 3 = reserved, treated as NONE.
REQ-007 proc2mem_addr  input  32  byte address; block index = addr[3 +: log2(MEM_DEPTH)]; other bits ignored, so out-of-range addresses alias.
REQ-008 proc2mem_data  input  64  store data.
REQ-009 mem2proc_transaction_tag  output  4  nonzero tag = command accepted; 0 = refused; registered.
REQ-010 mem2proc_data  output  64  load data; 0 whenever mem2proc_data_tag is 0; registered.
REQ-011 mem2proc_data_tag  output  4  tag of returned load; 0 = no return this cycle; registered.

Function
REQ-012 The block SHALL sample one command per rising edge; NONE and reserved commands have no effect, and the tag output is 0 on the following cycle.
REQ-013 The tag counter SHALL issue tags 1..15 in order, wrap 15->1, never issue 0, and advance only on accepted LOAD or STORE.
REQ-014 A LOAD SHALL be accepted at edge n iff the outstanding count after edge-n retirement is below MAX_OUTSTANDING (and no stall, REQ-022); retire and accept on the same edge are allowed when full.
REQ-015 An accepted LOAD SHALL capture the addressed block at edge n (read-at-accept) into an in-order queue entry with its tag and a LATENCY countdown.
REQ-016 mem2proc_transaction_tag SHALL show the issued tag from edge n to edge n+1; a refused command shows 0, does not modify the array, and does not advance the tag counter.
REQ-017 The queue head SHALL drive mem2proc_data_tag and mem2proc_data from edge n+LATENCY to edge n+LATENCY+1 only, then retire; data_tag and data are 0 on all other cycles.
REQ-018 A STORE SHALL never be refused for queue occupancy; it writes the block at acceptance edge n, receives a tag, allocates no queue entry, and produces no data return.
REQ-019 A LOAD accepted after a STORE to the same block SHALL return the stored value; a LOAD accepted before it SHALL return the old value.
REQ-020 Returns SHALL be in acceptance order, with at most one return per cycle; fixed latency guarantees no collision.

Reset
REQ-021 While reset is high: all outputs 0, queue empty, outstanding count 0, tag counter reloaded to 1, stall counter 0, all array blocks 0; reset mid-transaction discards in-flight loads with no return after release.

Configuration
REQ-022 With MEM_STALL_EN defined, a free-running 3-bit cycle counter (0 at reset) SHALL force refusal (tag 0, no effect) of any LOAD or STORE sampled on an edge where the counter reads 7. Without MEM_STALL_EN, the counter is absent and only REQ-014 refuses.

Verification
REQ-023 Reset, STORE addr 0x08 data 0xDEAD_BEEF_0000_0001 at edge 1 -> tag 1 in cycle 1 -> LOAD addr 0x08 at edge 2 -> tag 2; data_tag 2 with that data after edge 6, one cycle only.
REQ-024 LOADs on three consecutive edges, defaults -> tags 1, 2, then 0 for the third; data_tags 1 and 2 on consecutive cycles after LATENCY; the tag counter then stands at 3.
REQ-025 Issue 16 accepted commands -> tags 1..15 then 1; tag 0 is never issued for an accepted command.
REQ-026 LOAD A at edge n, STORE A new value at edge n+1 -> the load returns the old value; a later LOAD returns the new value; addr 0x208 with MEM_DEPTH=64 aliases to block 1.
REQ-027 Assert reset asynchronously mid-cycle with 2 loads in flight -> outputs 0 immediately; no data_tag after release; next accepted tag is 1.
REQ-028 With MEM_STALL_EN, a LOAD every 4 cycles from reset -> the command sampled at counter 7 gets tag 0 and no return; all others return normally.
